// File: rtl/cache_nway_lru_pkg.sv
// Shared definitions for the N-way LRU cache: sweep states, access-size
// encoding, address field width helper and the load/store data alignment.
package cache_nway_lru_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } sweep_state_t;

  localparam int UBHW_UNSIGNED = 2;
  localparam int UBHW_WORD     = 1;
  localparam int UBHW_HALF     = 0;

  function automatic int cache_tag_bits(input int addr_bits, input int sets, input int line_words);
    return addr_bits - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] ubhw);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] result;
    half_v = word[{off[1], 4'b0000} +: 16];
    byte_v = word[{off, 3'b000} +: 8];
    if (ubhw[UBHW_WORD])
      result = word;
    else if (ubhw[UBHW_HALF])
      result = ubhw[UBHW_UNSIGNED] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
    else
      result = ubhw[UBHW_UNSIGNED] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
    return result;
  endfunction

  // Only the addressed lane changes; the rest of the stored word is kept.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] din,
                                              input logic [1:0] off, input logic [2:0] ubhw);
    logic [31:0] merged;
    merged = old_word;
    if (ubhw[UBHW_WORD])
      merged = din;
    else if (ubhw[UBHW_HALF])
      merged[{off[1], 4'b0000} +: 16] = din[15:0];
    else
      merged[{off, 3'b000} +: 8] = din[7:0];
    return merged;
  endfunction

endpackage

// File: rtl/cache_nway_lru_if.sv
// Command/status bus between the memory stage / cache controller and the cache array.
interface cache_nway_lru_if #(
  parameter int ADDR_BITS  = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
);
  import cache_nway_lru_pkg::*;

  localparam int TAG_BITS = cache_tag_bits(ADDR_BITS, SETS, LINE_WORDS);
  localparam int WAY_BITS = $clog2(WAYS);

  logic [ADDR_BITS-1:0] addr;
  logic                 load;
  logic                 store;
  logic                 edit;
  logic                 invalid;
  logic                 flush;
  logic [2:0]           u_b_h_w;
  logic [31:0]          din;
  logic                 hit;
  logic [31:0]          dout;
  logic                 valid;
  logic                 dirty;
  logic [TAG_BITS-1:0]  tag;
  logic [WAY_BITS-1:0]  victim_way;
  logic                 busy;
  logic                 flush_done;

  modport master (
    output addr, load, store, edit, invalid, flush, u_b_h_w, din,
    input  hit, dout, valid, dirty, tag, victim_way, busy, flush_done
  );

  modport slave (
    input  addr, load, store, edit, invalid, flush, u_b_h_w, din,
    output hit, dout, valid, dirty, tag, victim_way, busy, flush_done
  );

endinterface

// File: rtl/cache_nway_lru_ages.sv
// Per-set true-LRU age counters; ages in a set always form a permutation of 0..WAYS-1.
module cache_nway_lru_ages #(
  parameter  int WAYS     = 4,
  parameter  int SETS     = 32,
  localparam int WAY_BITS = $clog2(WAYS),
  localparam int SET_BITS = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] set_idx,
  input  logic                touch_en,
  input  logic [WAY_BITS-1:0] touch_way,
  input  logic                clear_en,
  input  logic [SET_BITS-1:0] clear_set,
  output logic [WAY_BITS-1:0] lru_way
);

  logic [WAY_BITS-1:0] age_q [SETS][WAYS];

  // A touch moves the way to age 0 and ages only the ways that were younger than it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_BITS'(w);
    end else if (clear_en) begin
      for (int w = 0; w < WAYS; w++)
        age_q[clear_set][w] <= WAY_BITS'(w);
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == touch_way)
          age_q[set_idx][w] <= '0;
        else if (age_q[set_idx][w] < age_q[set_idx][touch_way])
          age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[set_idx][w] == WAY_BITS'(WAYS - 1))
        lru_way = WAY_BITS'(w);
  end

endmodule

// File: rtl/cache_nway_lru.sv
// N-way set-associative write-back data cache array with true-LRU replacement
// and a one-set-per-cycle flush sweep.
module cache_nway_lru
  import cache_nway_lru_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input logic             clk,
  input logic             rst,
  cache_nway_lru_if.slave bus
);

  localparam int SET_BITS  = $clog2(SETS);
  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int TAG_BITS  = cache_tag_bits(ADDR_BITS, SETS, LINE_WORDS);

  logic [WAYS-1:0]     valid_q  [SETS];
  logic [WAYS-1:0]     dirty_q  [SETS];
  logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
  logic [31:0]         data_mem [SETS][WAYS][LINE_WORDS];

  sweep_state_t        state;
  logic [SET_BITS-1:0] sweep_cnt;

  logic [1:0]           byte_off;
  logic [WORD_BITS-1:0] word_idx;
  logic [SET_BITS-1:0]  set_idx;
  logic [TAG_BITS-1:0]  addr_tag;
  logic                 hit_any, inv_found, active, sweeping;
  logic [WAY_BITS-1:0]  hit_way, inv_way, lru_way, victim;
  logic                 do_invalid, do_store, do_edit, do_load;
  logic [31:0]          victim_word;

  assign byte_off = bus.addr[1:0];
  assign word_idx = bus.addr[2 +: WORD_BITS];
  assign set_idx  = bus.addr[2 + WORD_BITS +: SET_BITS];
  assign addr_tag = bus.addr[ADDR_BITS-1 -: TAG_BITS];

  // Victim: the hitting way, else the lowest invalid way, else the oldest way.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_mem[set_idx][w] == addr_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[set_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    if (hit_any)
      victim = hit_way;
    else if (inv_found)
      victim = inv_way;
    else
      victim = lru_way;
  end

  // A flush request in an idle cycle takes precedence over any command in it.
  assign sweeping    = (state == ST_SWEEP);
  assign active      = !sweeping && !bus.flush;
  assign do_invalid  = active && bus.invalid;
  assign do_store    = active && !bus.invalid && bus.store;
  assign do_edit     = active && !bus.invalid && !bus.store && bus.edit;
  assign do_load     = active && !bus.invalid && !bus.store && !bus.edit && bus.load;
  assign victim_word = data_mem[set_idx][victim][word_idx];

  cache_nway_lru_ages #(.WAYS(WAYS), .SETS(SETS)) u_ages (
    .clk       (clk),
    .rst       (rst),
    .set_idx   (set_idx),
    .touch_en  ((do_load || do_edit) && hit_any),
    .touch_way (hit_way),
    .clear_en  (sweeping || do_invalid),
    .clear_set (sweeping ? sweep_cnt : set_idx),
    .lru_way   (lru_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (sweeping) begin
      valid_q[sweep_cnt] <= '0;
      dirty_q[sweep_cnt] <= '0;
    end else if (do_invalid) begin
      valid_q[set_idx] <= '0;
      dirty_q[set_idx] <= '0;
    end else if (do_store) begin
      valid_q[set_idx][victim] <= 1'b1;
      dirty_q[set_idx][victim] <= 1'b0;
    end else if (do_edit && hit_any) begin
      dirty_q[set_idx][hit_way] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && do_store) begin
      tag_mem[set_idx][victim]            <= addr_tag;
      data_mem[set_idx][victim][word_idx] <= bus.din;
    end else if (!rst && do_edit && hit_any) begin
      data_mem[set_idx][hit_way][word_idx] <= store_merge(victim_word, bus.din, byte_off, bus.u_b_h_w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      sweep_cnt      <= '0;
      bus.hit        <= 1'b0;
      bus.dout       <= '0;
      bus.valid      <= 1'b0;
      bus.dirty      <= 1'b0;
      bus.tag        <= '0;
      bus.victim_way <= '0;
      bus.busy       <= 1'b0;
      bus.flush_done <= 1'b0;
    end else begin
      bus.flush_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.flush) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
            bus.busy  <= 1'b1;
            bus.hit   <= 1'b0;
          end else begin
            bus.hit        <= hit_any;
            bus.valid      <= valid_q[set_idx][victim];
            bus.dirty      <= dirty_q[set_idx][victim];
            bus.tag        <= tag_mem[set_idx][victim];
            bus.victim_way <= victim;
            // A load miss leaves dout alone; any non-load cycle shows the write-back word.
            if (do_load) begin
              if (hit_any)
                bus.dout <= load_extend(victim_word, byte_off, bus.u_b_h_w);
            end else begin
              bus.dout <= victim_word;
            end
          end
        end
        ST_SWEEP: begin
          bus.hit <= 1'b0;
          if (sweep_cnt == SET_BITS'(SETS - 1)) begin
            state          <= ST_IDLE;
            bus.busy       <= 1'b0;
            bus.flush_done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
